sniff_fifo_arbiter: RTL and testbench



---
 rtl/sniff_fifo_arbiter.sv | 107 ++++++++++
 tb/tb_sniff_fifo_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sniff_fifo_arbiter.sv
// Round-robin, packet-aware arbiter sharing one capture FIFO write port between two sniffers.
// Optional per-grant channel header byte is enabled with SNIFF_ARB_HDR_EN.
module sniff_fifo_arbiter #(
  parameter int unsigned BURST_MAX = 16,
  parameter logic [6:0]  HDR_MARK  = 7'h55
) (
  input  logic       clk,
  input  logic       srst_n,
  input  logic [7:0] s0_data,
  input  logic       s0_valid,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic [7:0] s1_data,
  input  logic       s1_valid,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic [7:0] fifo_din,
  output logic       fifo_wr_en,
  input  logic       fifo_full,
  output logic [1:0] grant,
  output logic       busy
);

  if ((BURST_MAX < 1) || (BURST_MAX > 255) || ($bits(HDR_MARK) != 7)) begin : g_param_err
    $error("sniff_fifo_arbiter: BURST_MAX must be in 1..255");
  end

  localparam logic [7:0] BurstLast = 8'(BURST_MAX - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic [7:0] beat_q;
  logic       rr_q;     // 0: channel 0 wins a tie, 1: channel 1 wins
  logic       ch;
  logic       ch_last;

  assign ch      = grant_q[1];
  assign ch_last = ch ? s1_last : s0_last;
  assign grant   = grant_q;
  assign busy    = (state_q != StIdle);

  // Data path is combinational so a granted byte moves in the same cycle it is offered.
  always_comb begin
    fifo_din   = 8'h00;
    fifo_wr_en = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    unique case (state_q)
      StData: begin
        fifo_din   = ch ? s1_data : s0_data;
        fifo_wr_en = (ch ? s1_valid : s0_valid) & ~fifo_full;
        s0_ready   = grant_q[0] & ~fifo_full;
        s1_ready   = grant_q[1] & ~fifo_full;
      end
`ifdef SNIFF_ARB_HDR_EN
      StHdr: begin
        fifo_din   = {HDR_MARK, ch};
        fifo_wr_en = ~fifo_full;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srst_n) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      beat_q  <= 8'h00;
      rr_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (s0_valid || s1_valid) begin
            if (s0_valid && (!s1_valid || !rr_q)) grant_q <= 2'b01;
            else                                  grant_q <= 2'b10;
            beat_q <= 8'h00;
`ifdef SNIFF_ARB_HDR_EN
            state_q <= StHdr;
`else
            state_q <= StData;
`endif
          end
        end
`ifdef SNIFF_ARB_HDR_EN
        StHdr: begin
          if (!fifo_full) state_q <= StData;
        end
`endif
        StData: begin
          if (fifo_wr_en) begin
            if (ch_last || (beat_q == BurstLast)) begin
              state_q <= StIdle;
              grant_q <= 2'b00;
              rr_q    <= ~ch;
            end
            beat_q <= beat_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sniff_fifo_arbiter.sv
// Scoreboard bench for sniff_fifo_arbiter: directed packets, expected FIFO bytes queued up front.
module tb_sniff_fifo_arbiter;

`ifdef SNIFF_ARB_HDR_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic       clk;
  logic       srst_n;
  logic [7:0] s0_data, s1_data;
  logic       s0_valid, s0_last, s0_ready;
  logic       s1_valid, s1_last, s1_ready;
  logic [7:0] fifo_din;
  logic       fifo_wr_en, fifo_full;
  logic [1:0] grant;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [8:0] cq0[$];
  logic [8:0] cq1[$];
  logic [7:0] exp_q[$];
  logic [1:0] glog[$];

  sniff_fifo_arbiter #(.BURST_MAX(16), .HDR_MARK(7'h55)) dut (
    .clk       (clk),
    .srst_n    (srst_n),
    .s0_data   (s0_data),
    .s0_valid  (s0_valid),
    .s0_last   (s0_last),
    .s0_ready  (s0_ready),
    .s1_data   (s1_data),
    .s1_valid  (s1_valid),
    .s1_last   (s1_last),
    .s1_ready  (s1_ready),
    .fifo_din  (fifo_din),
    .fifo_wr_en(fifo_wr_en),
    .fifo_full (fifo_full),
    .grant     (grant),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic void push_hdr(input logic ch);
    if (HdrEn) exp_q.push_back({7'h55, ch});
  endfunction

  // Channel 0 source: pops on an observed handshake, presents queue head 1 time unit after the edge.
  initial begin
    logic acc;
    s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
    forever begin
      @(negedge clk);
      acc = s0_valid && s0_ready;
      @(posedge clk);
      if (acc && cq0.size() > 0) void'(cq0.pop_front());
      #1;
      if (cq0.size() > 0) begin
        {s0_last, s0_data} = cq0[0];
        s0_valid = 1'b1;
      end else s0_valid = 1'b0;
    end
  end

  initial begin
    logic acc;
    s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
    forever begin
      @(negedge clk);
      acc = s1_valid && s1_ready;
      @(posedge clk);
      if (acc && cq1.size() > 0) void'(cq1.pop_front());
      #1;
      if (cq1.size() > 0) begin
        {s1_last, s1_data} = cq1[0];
        s1_valid = 1'b1;
      end else s1_valid = 1'b0;
    end
  end

  // Monitor: every FIFO write is popped against the scoreboard; grant changes are logged.
  initial begin
    logic [1:0] prev_g;
    prev_g = 2'b00;
    forever begin
      @(negedge clk);
      if (fifo_wr_en) begin
        check("wr_while_full", {31'd0, fifo_full}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %0h want none", fifo_din);
        end else check("fifo_din", {24'd0, fifo_din}, {24'd0, exp_q.pop_front()});
      end
      if (grant !== prev_g) begin
        glog.push_back(grant);
        prev_g = grant;
      end
    end
  end

  task automatic do_reset(input string name);
    srst_n = 1'b0;
    step();
    cq0.delete(); cq1.delete(); exp_q.delete();
    s0_valid = 1'b0; s1_valid = 1'b0;
    srst_n = 1'b1;
    @(negedge clk);
    check({name, "_grant"}, {30'd0, grant}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_wr_en"}, {31'd0, fifo_wr_en}, 32'd0);
    check({name, "_ready"}, {30'd0, s1_ready, s0_ready}, 32'd0);
    glog.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !busy && (cq0.size() == 0) && (cq1.size() == 0);
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_glog(input string name, input logic [1:0] e[$]);
    check({name, "_glog_len"}, glog.size(), e.size());
    for (int i = 0; i < e.size() && i < glog.size(); i++)
      check($sformatf("%s_glog%0d", name, i), {30'd0, glog[i]}, {30'd0, e[i]});
  endtask

  initial begin
    logic [1:0] ge[$];
    bit seen;
    fifo_full = 1'b0;
    srst_n    = 1'b0;
    do_reset("rst0");

    // Single ch0 packet: grant one cycle after valid, bytes on consecutive cycles.
    push_hdr(1'b0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    cq0.push_back({1'b0, 8'h11}); cq0.push_back({1'b0, 8'h22}); cq0.push_back({1'b1, 8'h33});
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = s0_valid;
    end
    check("t1_valid_seen", {31'd0, seen}, 32'd1);
    check("t1_grant_pre", {30'd0, grant}, 32'd0);
    @(negedge clk);
    check("t1_grant", {30'd0, grant}, 32'd1);
`ifdef SNIFF_ARB_HDR_EN
    check("t1_hdr_wr", {31'd0, fifo_wr_en}, 32'd1);
    @(negedge clk);
`endif
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_wr%0d", i), {31'd0, fifo_wr_en}, 32'd1);
      @(negedge clk);
    end
    check("t1_idle_after", {31'd0, busy}, 32'd0);
    wait_drain("t1", 20);
    ge = '{2'b01, 2'b00};
    check_glog("t1", ge);

    // Both channels request together: ch0 first, one idle cycle, then ch1.
    do_reset("rst2");
    push_hdr(1'b0); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    push_hdr(1'b1); exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    cq0.push_back({1'b0, 8'h31}); cq0.push_back({1'b1, 8'h32});
    cq1.push_back({1'b0, 8'h41}); cq1.push_back({1'b1, 8'h42});
    wait_drain("t2", 40);
    ge = '{2'b01, 2'b00, 2'b10, 2'b00};
    check_glog("t2", ge);

    // 20-byte ch1 packet truncated at 16, ch0 slips in, ch1 resumes.
    do_reset("rst3");
    push_hdr(1'b1);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hC0 + i));
    push_hdr(1'b0); exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    push_hdr(1'b1);
    for (int i = 16; i < 20; i++) exp_q.push_back(8'(8'hC0 + i));
    for (int i = 0; i < 20; i++) cq1.push_back({(i == 19), 8'(8'hC0 + i)});
    repeat (4) step();
    cq0.push_back({1'b0, 8'hA1}); cq0.push_back({1'b1, 8'hA2});
    wait_drain("t3", 200);
    ge = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    check_glog("t3", ge);

    // FIFO full for three cycles right after 0x22 is written.
    do_reset("rst4");
    push_hdr(1'b0);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    cq0.push_back({1'b0, 8'h11}); cq0.push_back({1'b0, 8'h22}); cq0.push_back({1'b1, 8'h33});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = fifo_wr_en && (fifo_din == 8'h22);
    end
    check("t4_saw_22", {31'd0, seen}, 32'd1);
    step();
    fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_full_wr%0d", i), {31'd0, fifo_wr_en}, 32'd0);
      check($sformatf("t4_full_rdy%0d", i), {31'd0, s0_ready}, 32'd0);
      check($sformatf("t4_full_busy%0d", i), {31'd0, busy}, 32'd1);
      step();
    end
    fifo_full = 1'b0;
    @(negedge clk);
    check("t4_resume_wr", {31'd0, fifo_wr_en}, 32'd1);
    check("t4_resume_din", {24'd0, fifo_din}, 32'h33);
    wait_drain("t4", 20);

    // Reset mid-packet, then a ch1 packet is arbitrated normally.
    do_reset("rst5");
    push_hdr(1'b0);
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'h61 + i));
    for (int i = 0; i < 5; i++) cq0.push_back({(i == 4), 8'(8'h61 + i)});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = fifo_wr_en && (fifo_din == 8'h62);
    end
    check("t5_saw_62", {31'd0, seen}, 32'd1);
    do_reset("t5_mid");
    push_hdr(1'b1); exp_q.push_back(8'h71); exp_q.push_back(8'h72);
    cq1.push_back({1'b0, 8'h71}); cq1.push_back({1'b1, 8'h72});
    wait_drain("t5", 30);
    ge = '{2'b10, 2'b00};
    check_glog("t5", ge);

`ifdef SNIFF_ARB_HDR_EN
    // Header bytes: ch1 -> 0xAB, ch0 -> 0xAA.
    do_reset("rst6");
    exp_q.push_back(8'hAB); exp_q.push_back(8'h5A);
    cq1.push_back({1'b1, 8'h5A});
    wait_drain("t6a", 20);
    exp_q.push_back(8'hAA); exp_q.push_back(8'h3C);
    cq0.push_back({1'b1, 8'h3C});
    wait_drain("t6b", 20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
